// File: rtl/regfile_writeback_if.sv
// ============================================================================
// Module      : regfile_writeback_if
// Description : Handshake and bus bundle for the register file write-side
//               controller. It carries issue reservations, ALU and load
//               results, decode source lookups and the register file write
//               port. The master side is the pipeline and register file. The
//               slave side is regfile_writeback.
// Config      : REGFILE_WB_BYPASS_EN adds the rsN_fwd / rsN_fwd_data signals.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_writeback_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  localparam int c_CNT_W = $clog2(DEPTH) + 1;

  logic              iss_valid;
  logic [4:0]        iss_rd;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              alu_ready;
  logic              lsu_valid;
  logic [4:0]        lsu_rd;
  logic [XLEN-1:0]   lsu_data;
  logic              lsu_ready;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic              rs1_busy;
  logic              rs2_busy;
  logic              we;
  logic [4:0]        rd;
  logic [XLEN-1:0]   rd_data;
  logic [c_CNT_W-1:0] count;
`ifdef REGFILE_WB_BYPASS_EN
  logic              rs1_fwd;
  logic [XLEN-1:0]   rs1_fwd_data;
  logic              rs2_fwd;
  logic [XLEN-1:0]   rs2_fwd_data;
`endif

  modport master (
    output iss_valid, iss_rd,
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    output rs1, rs2,
    input  rs1_busy, rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    input  rs1_fwd, rs1_fwd_data, rs2_fwd, rs2_fwd_data,
`endif
    input  we, rd, rd_data, count
  );

  modport slave (
    input  iss_valid, iss_rd,
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    input  rs1, rs2,
    output rs1_busy, rs2_busy,
`ifdef REGFILE_WB_BYPASS_EN
    output rs1_fwd, rs1_fwd_data, rs2_fwd, rs2_fwd_data,
`endif
    output we, rd, rd_data, count
  );

endinterface

`default_nettype wire

// File: rtl/regfile_writeback.sv
// ============================================================================
// Module      : regfile_writeback
// Description : Write-side controller for the 32x32 register file. ALU and
//               load results go into a circular write queue. The block drains
//               one write per cycle to the register file and keeps a busy
//               scoreboard of reserved destinations, which decode uses to
//               detect RAW hazards.
// Config      : REGFILE_WB_BYPASS_EN adds forwarding of the in-flight write
//               to the decode source lookups.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_writeback_if.slave io_wb
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  // Queue storage and pointers
  logic [4:0]          r_q_rd   [DEPTH];
  logic [XLEN-1:0]     r_q_data [DEPTH];
  logic [c_PTR_W-1:0]  r_head;
  logic [c_PTR_W-1:0]  r_tail;
  logic [c_CNT_W-1:0]  r_count;
  logic [31:1]         r_busy;

  logic [c_CNT_W-1:0]  w_free;
  logic                w_lsu_ready;
  logic                w_alu_ready;
  logic                w_push_lsu;
  logic                w_push_alu;
  logic                w_pop;
  logic [c_PTR_W-1:0]  w_alu_slot;
  logic [c_PTR_W-1:0]  w_tail_nxt;
  logic [c_CNT_W-1:0]  w_count_nxt;
  logic [4:0]          w_head_rd;
  logic [XLEN-1:0]     w_head_data;
  logic [31:1]         w_busy_nxt;
  logic [31:0]         w_busy_idx;
  logic                w_rs1_busy_raw;
  logic                w_rs2_busy_raw;

  // Readiness uses only registered occupancy. A same-cycle pop does not free a slot early.
  always_comb begin
    w_free      = c_CNT_W'(DEPTH) - r_count;
    w_lsu_ready = (w_free >= c_CNT_W'(1));
    w_alu_ready = (w_free >= c_CNT_W'(2)) ||
                  ((w_free == c_CNT_W'(1)) && !io_wb.lsu_valid);
    // Writes to x0 complete the handshake but are discarded.
    w_push_lsu  = io_wb.lsu_valid && w_lsu_ready && (io_wb.lsu_rd != 5'd0);
    w_push_alu  = io_wb.alu_valid && w_alu_ready && (io_wb.alu_rd != 5'd0);
    w_pop       = (r_count != '0);
    // The LSU entry takes the tail slot first; the ALU entry follows it.
    w_alu_slot  = w_push_lsu ? (r_tail + c_PTR_W'(1)) : r_tail;
    w_tail_nxt  = r_tail + c_PTR_W'(w_push_lsu) + c_PTR_W'(w_push_alu);
    w_count_nxt = r_count + c_CNT_W'(w_push_lsu) + c_CNT_W'(w_push_alu)
                  - c_CNT_W'(w_pop);
    w_head_rd   = w_pop ? r_q_rd[r_head]   : 5'd0;
    w_head_data = w_pop ? r_q_data[r_head] : '0;
  end

  // Queue pointers, occupancy and entry storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_rd[i]   <= 5'd0;
        r_q_data[i] <= '0;
      end
    end else begin
      if (w_push_lsu) begin
        r_q_rd[r_tail]   <= io_wb.lsu_rd;
        r_q_data[r_tail] <= io_wb.lsu_data;
      end
      if (w_push_alu) begin
        r_q_rd[w_alu_slot]   <= io_wb.alu_rd;
        r_q_data[w_alu_slot] <= io_wb.alu_data;
      end
      if (w_pop) begin
        r_head <= r_head + c_PTR_W'(1);
      end
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Scoreboard update: a pop clears the head destination, and a new reservation wins over that clear.
  always_comb begin
    for (int i = 1; i < 32; i++) begin
      w_busy_nxt[i] = (r_busy[i] && !(w_pop && (w_head_rd == 5'(i)))) ||
                      (io_wb.iss_valid && (io_wb.iss_rd == 5'(i)));
    end
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // Source lookups and register file write port
  always_comb begin
    w_busy_idx     = {r_busy, 1'b0};
    w_rs1_busy_raw = (io_wb.rs1 != 5'd0) && w_busy_idx[io_wb.rs1];
    w_rs2_busy_raw = (io_wb.rs2 != 5'd0) && w_busy_idx[io_wb.rs2];
  end

  assign io_wb.lsu_ready = w_lsu_ready;
  assign io_wb.alu_ready = w_alu_ready;
  assign io_wb.we        = w_pop;
  assign io_wb.rd        = w_head_rd;
  assign io_wb.rd_data   = w_head_data;
  assign io_wb.count     = r_count;

`ifdef REGFILE_WB_BYPASS_EN
  logic w_rs1_fwd;
  logic w_rs2_fwd;

  // Forward the write in flight. This is for a register file whose read lags the write by one edge.
  always_comb begin
    w_rs1_fwd = w_pop && (io_wb.rs1 != 5'd0) && (w_head_rd == io_wb.rs1);
    w_rs2_fwd = w_pop && (io_wb.rs2 != 5'd0) && (w_head_rd == io_wb.rs2);
  end

  assign io_wb.rs1_fwd      = w_rs1_fwd;
  assign io_wb.rs2_fwd      = w_rs2_fwd;
  assign io_wb.rs1_fwd_data = w_head_data;
  assign io_wb.rs2_fwd_data = w_head_data;
  assign io_wb.rs1_busy     = w_rs1_busy_raw && !w_rs1_fwd;
  assign io_wb.rs2_busy     = w_rs2_busy_raw && !w_rs2_fwd;
`else
  assign io_wb.rs1_busy     = w_rs1_busy_raw;
  assign io_wb.rs2_busy     = w_rs2_busy_raw;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_writeback.sv
// ============================================================================
// Module      : tb_regfile_writeback
// Description : Directed bench for regfile_writeback. It covers reset/idle,
//               a single ALU write, simultaneous sources, backpressure, x0
//               writes, scoreboard set-over-clear, bypass (when
//               REGFILE_WB_BYPASS_EN is defined) and reset during a drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_writeback;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_writeback_if #(.XLEN(XLEN), .DEPTH(DEPTH)) u_wb_if ();

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_wb (u_wb_if)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  task automatic clr_src();
    u_wb_if.iss_valid = 1'b0;
    u_wb_if.alu_valid = 1'b0;
    u_wb_if.lsu_valid = 1'b0;
  endtask

  task automatic drv_alu(input logic [4:0] r, input logic [31:0] d);
    u_wb_if.alu_valid = 1'b1;
    u_wb_if.alu_rd    = r;
    u_wb_if.alu_data  = d;
  endtask

  task automatic drv_lsu(input logic [4:0] r, input logic [31:0] d);
    u_wb_if.lsu_valid = 1'b1;
    u_wb_if.lsu_rd    = r;
    u_wb_if.lsu_data  = d;
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
    chk({tag, "_we"},   32'(u_wb_if.we), 32'd1);
    chk({tag, "_rd"},   32'(u_wb_if.rd), 32'(r));
    chk({tag, "_data"}, u_wb_if.rd_data, d);
    chk({tag, "_cnt_le_depth"}, 32'(u_wb_if.count <= 3'd4), 32'd1);
  endtask

  initial begin
    u_wb_if.iss_valid = 1'b0;
    u_wb_if.iss_rd    = 5'd0;
    u_wb_if.alu_valid = 1'b0;
    u_wb_if.alu_rd    = 5'd0;
    u_wb_if.alu_data  = 32'd0;
    u_wb_if.lsu_valid = 1'b0;
    u_wb_if.lsu_rd    = 5'd0;
    u_wb_if.lsu_data  = 32'd0;
    u_wb_if.rs1       = 5'd5;
    u_wb_if.rs2       = 5'd9;

    // Reset state
    #12;
    chk("rst_we",    32'(u_wb_if.we),      32'd0);
    chk("rst_count", 32'(u_wb_if.count),   32'd0);
    chk("rst_rd",    32'(u_wb_if.rd),      32'd0);
    chk("rst_data",  u_wb_if.rd_data,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle for five cycles
    for (int i = 0; i < 5; i++) begin
      tick(); settle();
      chk("idle_we",    32'(u_wb_if.we),       32'd0);
      chk("idle_count", 32'(u_wb_if.count),    32'd0);
      chk("idle_rs1b",  32'(u_wb_if.rs1_busy), 32'd0);
      chk("idle_rs2b",  32'(u_wb_if.rs2_busy), 32'd0);
    end

    // Single ALU write to x5
    tick(); u_wb_if.iss_valid = 1'b1; u_wb_if.iss_rd = 5'd5; settle();
    chk("alu1_c1_busy", 32'(u_wb_if.rs1_busy), 32'd0);
    tick(); clr_src(); settle();
    chk("alu1_c2_busy", 32'(u_wb_if.rs1_busy), 32'd1);
    tick(); drv_alu(5'd5, 32'hDEADBEEF); settle();
    chk("alu1_c3_rdy",  32'(u_wb_if.alu_ready), 32'd1);
    chk("alu1_c3_busy", 32'(u_wb_if.rs1_busy),  32'd1);
    chk("alu1_c3_we",   32'(u_wb_if.we),        32'd0);
    tick(); clr_src(); settle();
    chk_wr("alu1_c4", 5'd5, 32'hDEADBEEF);
`ifdef REGFILE_WB_BYPASS_EN
    chk("alu1_c4_busy", 32'(u_wb_if.rs1_busy), 32'd0);
`else
    chk("alu1_c4_busy", 32'(u_wb_if.rs1_busy), 32'd1);
`endif
    tick(); settle();
    chk("alu1_c5_busy",  32'(u_wb_if.rs1_busy), 32'd0);
    chk("alu1_c5_count", 32'(u_wb_if.count),    32'd0);
    chk("alu1_c5_we",    32'(u_wb_if.we),       32'd0);

    // Both sources in the same cycle on an empty queue
    tick(); drv_lsu(5'd7, 32'h11); drv_alu(5'd8, 32'h22); settle();
    chk("dual_lsu_rdy", 32'(u_wb_if.lsu_ready), 32'd1);
    chk("dual_alu_rdy", 32'(u_wb_if.alu_ready), 32'd1);
    tick(); clr_src(); settle();
    chk_wr("dual_w0", 5'd7, 32'h11);
    chk("dual_w0_cnt", 32'(u_wb_if.count), 32'd2);
    tick(); settle();
    chk_wr("dual_w1", 5'd8, 32'h22);
    chk("dual_w1_cnt", 32'(u_wb_if.count), 32'd1);
    tick(); settle();
    chk("dual_empty_we",  32'(u_wb_if.we),    32'd0);
    chk("dual_empty_cnt", 32'(u_wb_if.count), 32'd0);

    // Backpressure: fill to three entries, then offer both sources
    tick(); drv_lsu(5'd10, 32'h10A); drv_alu(5'd11, 32'h10B); settle();
    tick(); drv_lsu(5'd13, 32'h10D); drv_alu(5'd12, 32'h10C); settle();
    chk("bp_b_cnt",     32'(u_wb_if.count),     32'd2);
    chk("bp_b_alu_rdy", 32'(u_wb_if.alu_ready), 32'd1);
    chk_wr("bp_b", 5'd10, 32'h10A);
    tick(); drv_lsu(5'd14, 32'h10E); drv_alu(5'd15, 32'h10F); settle();
    chk("bp_c_cnt",     32'(u_wb_if.count),     32'd3);
    chk("bp_c_lsu_rdy", 32'(u_wb_if.lsu_ready), 32'd1);
    chk("bp_c_alu_rdy", 32'(u_wb_if.alu_ready), 32'd0);
    chk_wr("bp_c", 5'd11, 32'h10B);
    tick(); u_wb_if.lsu_valid = 1'b0; settle();
    chk("bp_d_cnt",     32'(u_wb_if.count),     32'd3);
    chk("bp_d_alu_rdy", 32'(u_wb_if.alu_ready), 32'd1);
    chk_wr("bp_d", 5'd13, 32'h10D);
    tick(); clr_src(); settle();
    chk("bp_e_cnt", 32'(u_wb_if.count), 32'd3);
    chk_wr("bp_e", 5'd12, 32'h10C);
    tick(); settle();
    chk_wr("bp_f", 5'd14, 32'h10E);
    tick(); settle();
    chk_wr("bp_g", 5'd15, 32'h10F);
    chk("bp_g_cnt", 32'(u_wb_if.count), 32'd1);
    tick(); settle();
    chk("bp_end_we", 32'(u_wb_if.we), 32'd0);

    // A write to x0 is accepted and discarded
    tick(); drv_alu(5'd0, 32'h55); settle();
    chk("x0_rdy", 32'(u_wb_if.alu_ready), 32'd1);
    tick(); clr_src(); settle();
    chk("x0_we",  32'(u_wb_if.we),    32'd0);
    chk("x0_cnt", 32'(u_wb_if.count), 32'd0);

    // Set of busy[9] in the same cycle as the pop of rd=9: set wins
    tick(); u_wb_if.iss_valid = 1'b1; u_wb_if.iss_rd = 5'd9; settle();
    tick(); clr_src(); drv_alu(5'd9, 32'h99); settle();
    tick(); clr_src(); u_wb_if.iss_valid = 1'b1; u_wb_if.iss_rd = 5'd9; settle();
    chk_wr("sc_pop", 5'd9, 32'h99);
    tick(); clr_src(); settle();
    chk("sc_busy_kept", 32'(u_wb_if.rs2_busy), 32'd1);
    chk("sc_we",        32'(u_wb_if.we),       32'd0);
    tick(); drv_alu(5'd9, 32'h9A); settle();
    tick(); clr_src(); settle();
    chk_wr("sc_pop2", 5'd9, 32'h9A);
    tick(); settle();
    chk("sc_busy_clr", 32'(u_wb_if.rs2_busy), 32'd0);

    // Source lookup during the write cycle of x3
    tick(); u_wb_if.iss_valid = 1'b1; u_wb_if.iss_rd = 5'd3; settle();
    tick(); clr_src(); drv_alu(5'd3, 32'h1234); settle();
    tick(); clr_src(); u_wb_if.rs1 = 5'd3; settle();
    chk_wr("byp", 5'd3, 32'h1234);
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_fwd",      32'(u_wb_if.rs1_fwd),  32'd1);
    chk("byp_fwd_data", u_wb_if.rs1_fwd_data,  32'h1234);
    chk("byp_busy",     32'(u_wb_if.rs1_busy), 32'd0);
    chk("byp_rs2_fwd",  32'(u_wb_if.rs2_fwd),  32'd0);
`else
    chk("byp_busy",     32'(u_wb_if.rs1_busy), 32'd1);
`endif
    tick(); settle();
    chk("byp_after_busy", 32'(u_wb_if.rs1_busy), 32'd0);

    // Asynchronous reset during a drain drops queued writes
    tick(); u_wb_if.iss_valid = 1'b1; u_wb_if.iss_rd = 5'd20;
    drv_lsu(5'd20, 32'h20); drv_alu(5'd21, 32'h21); settle();
    tick(); clr_src(); u_wb_if.rs1 = 5'd20; settle();
    chk("mr_pre_cnt",  32'(u_wb_if.count),    32'd2);
    chk("mr_pre_busy", 32'(u_wb_if.rs1_busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_we",   32'(u_wb_if.we),       32'd0);
    chk("mr_cnt",  32'(u_wb_if.count),    32'd0);
    chk("mr_rd",   32'(u_wb_if.rd),       32'd0);
    chk("mr_data", u_wb_if.rd_data,       32'd0);
    chk("mr_busy", 32'(u_wb_if.rs1_busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(); settle();
    chk("mr_post_we",  32'(u_wb_if.we),    32'd0);
    chk("mr_post_cnt", 32'(u_wb_if.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side controller for the 32x32 register file: collects writeback results from the ALU and the load/store unit, and queues them in a small FIFO.
- Drives the register file write port (we, rd, rd_data) with one write per cycle.
- Holds a 31-bit scoreboard of reserved destinations so decode can stall on pending writes (RAW hazards).
- Sits between the execute/memory stages and the register file.

Parameters:
DEPTH, 4, write-queue entries; power of two, >= 2
XLEN, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
iss_valid  in  1  decode issues an instruction that writes iss_rd
iss_rd  in  5  destination to reserve
alu_valid  in  1  ALU result valid
alu_rd  in  5  ALU destination
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle when high with alu_valid
lsu_valid  in  1  load result valid
lsu_rd  in  5  load destination
lsu_data  in  XLEN  load result
lsu_ready  out  1  load result accepted this cycle when high with lsu_valid
rs1  in  5  decode source 1
rs2  in  5  decode source 2
rs1_busy  out  1  source 1 has a pending write
rs2_busy  out  1  source 2 has a pending write
we  out  1  register file write enable
rd  out  5  register file write index
rd_data  out  XLEN  register file write data
count  out  clog2(DEPTH)+1  current queue occupancy

Behaviour:
- Reset (rst=0, asynchronous):
  - queue emptied, count=0, all busy bits cleared.
  - we=0, rd=0, rd_data=0 immediately.
  - A reset mid-drain drops all queued writes.
- Queue:
  - Circular FIFO with head/tail pointers and an occupancy counter.
  - free = DEPTH - count, computed from registered count only. A same-cycle pop does not raise readiness.
  - lsu_ready = (free >= 1).
  - alu_ready = (free >= 2) || (free == 1 && !lsu_valid).
  - Same-cycle accept from both sources: LSU entry is enqueued first, ALU entry second.
  - A handshake with rd==0 is accepted but not stored, and does not change count.
  - valid without ready: no enqueue; the source must hold its data.
- Drain:
  - we = (count != 0); rd and rd_data are taken from the head entry, combinationally from queue state.
  - rd and rd_data are 0 when the queue is empty.
  - Every cycle with we=1, the head is popped at the clock edge; the register file always accepts.
  - Latency: a result accepted in cycle N appears on we/rd/rd_data in cycle N+1 at the earliest.
  - Results are written strictly in acceptance order.
  - Pointers wrap modulo DEPTH.
  - count_next = count + pushes - pop, where pushes is 0..2; it never exceeds DEPTH.
- Scoreboard:
  - busy[31:1] register.
  - iss_valid && iss_rd!=0 sets busy[iss_rd].
  - A pop clears busy[head rd].
  - Set and clear of the same index in the same cycle: set wins.
  - rsN_busy = (rsN != 0) && busy[rsN], combinational.
  - Two queued writes to the same rd: the first pop clears the bit. Decode must not issue a second writer of an rd that is busy.

Optional Feature:
- Macro: REGFILE_WB_BYPASS_EN.
- Defined:
  - Adds outputs rs1_fwd (1), rs1_fwd_data (XLEN), rs2_fwd (1), rs2_fwd_data (XLEN).
  - rsN_fwd = we && rsN!=0 && rd==rsN; rsN_fwd_data = rd_data.
  - rsN_busy is forced to 0 when rsN_fwd=1, so decode consumes the forwarded value instead of stalling. This covers the case where the register file read lags the write by one edge.
- Undefined: the ports are absent and rsN_busy stays high through the write cycle.

Test Plan:
- Reset then idle: release rst, hold all valids low for 5 cycles -> we=0, count=0, rs1_busy=rs2_busy=0 throughout.
- Single ALU write: iss_rd=5 at cycle 1; alu_valid, alu_rd=5, alu_data=0xDEADBEEF at cycle 3.
  - rs1=5 reports busy=1 in cycles 2-4.
  - In cycle 4: we=1, rd=5, rd_data=0xDEADBEEF.
  - From cycle 5: busy=0 and count=0.
- Simultaneous sources with empty queue: lsu (rd=7, 0x11) and alu (rd=8, 0x22) in the same cycle.
  - Both are accepted.
  - Next cycle: we=1, rd=7, rd_data=0x11.
  - The cycle after: rd=8, rd_data=0x22.
- Backpressure with DEPTH=4 and count=3:
  - lsu_valid and alu_valid together -> lsu_ready=1, alu_ready=0.
  - ALU is accepted the following cycle after the drain.
  - count never exceeds 4.
- x0 and same-index set/clear:
  - alu_rd=0 with data 0x55 -> accepted, we stays 0.
  - iss_rd=9 in the same cycle as a pop of rd=9 -> busy[9] remains 1.
- Bypass, macro defined: write of 0x1234 to rd=3 in the we cycle with rs1=3 -> rs1_fwd=1, rs1_fwd_data=0x1234, rs1_busy=0.
